romarb_n: RTL

- N-channel successor to the two-channel PRG/CHR ROM arbiter.
- Serialises byte reads from NCH requesters (PRG, CHR, expansion/mapper, APU sample fetch) onto the single external ROM req/ack port.
- Before serving any channel, preloads the cartridge header.
- Adds configurable channel count, widths, round-robin or fixed-priority mode, per-channel base offsets, and header re-load on init.

---
 rtl/romarb_n_pkg.sv | 21 ++
 rtl/romarb_n_rr_pick.sv | 35 +++
 rtl/romarb_n.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/romarb_n_pkg.sv
// Shared definitions for the N-channel ROM arbiter: state encodings,
// iNES header constants and a small index-width helper.
package romarb_n_pkg;

   typedef enum logic [2:0] {
      ST_WAITINIT = 3'd0,
      ST_HDR      = 3'd1,
      ST_IDLE     = 3'd2,
      ST_BUSY     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int unsigned INES_HDRLEN = 16;
   localparam int unsigned INES_BYTE_W = 8;

   // Width of an index into n items; never less than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/romarb_n_rr_pick.sv
// Combinational NCH-wide selector: round-robin from a pointer, or fixed
// priority (lowest index) when rr_mode is low.
module romarb_n_rr_pick
   import romarb_n_pkg::*;
#(
   parameter int unsigned NCH = 2,
   parameter int unsigned PW  = idx_width(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   input  logic           rr_mode,
   output logic [PW-1:0]  grant_c,
   output logic           any_c
);

   // Channel examined at scan position k; ptr is always kept below NCH.
   function automatic int slot(input logic [PW-1:0] base, input logic en, input int k);
      int s;
      s = k + (en ? int'(base) : 0);
      if (s >= int'(NCH)) s = s - int'(NCH);
      return s;
   endfunction

   // Scan from the far end so the earliest matching position wins.
   always_comb begin
      grant_c = '0;
      any_c   = |req;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         for (int j = 0; j < int'(NCH); j++) begin
            if (req[j] && (j == slot(ptr, rr_mode, k))) grant_c = PW'(j);
         end
      end
   end

endmodule

// File: rtl/romarb_n.sv
// N-channel ROM read arbiter: loads the cartridge header after init, then
// serialises per-channel byte reads onto one external req/ack ROM port.
module romarb_n
   import romarb_n_pkg::*;
#(
   parameter int unsigned NCH    = 2,
   parameter int unsigned AW     = 21,
   parameter int unsigned ROMAW  = 22,
   parameter int unsigned DW     = 8,
   parameter int unsigned HDRLEN = INES_HDRLEN,
   parameter int unsigned RR     = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            init,
   input  logic [NCH-1:0]                  chreq,
   input  logic [NCH*AW-1:0]               chaddr,
   input  logic [NCH*ROMAW-1:0]            chbase,
   output logic [NCH-1:0]                  chack,
   output logic [DW-1:0]                   chdata,
   output logic [ROMAW-1:0]                romaddr,
   output logic                            romreq,
   input  logic                            romack,
   input  logic [DW-1:0]                   romdata,
   output logic [HDRLEN*INES_BYTE_W-1:0]   header,
   output logic                            hdrvalid,
   output logic                            busy
);

   localparam int unsigned PW = idx_width(NCH);
   localparam int unsigned CW = idx_width(HDRLEN);
   localparam int unsigned BW = INES_BYTE_W;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [PW-1:0]           gnt_q, gnt_d;
   logic                    pend_q, pend_d;
   logic [NCH-1:0]          chack_d;
   logic [DW-1:0]           chdata_d;
   logic [ROMAW-1:0]        romaddr_d;
   logic                    romreq_d;
   logic [HDRLEN*BW-1:0]    header_d;
   logic                    hdrvalid_d;
   logic                    busy_d;

   logic [PW-1:0]           pick_c;
   logic                    any_c;
   logic [AW-1:0]           sel_addr;
   logic [ROMAW-1:0]        sel_base;
   logic [ROMAW-1:0]        chan_addr;
   logic                    start_hdr;

   romarb_n_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
      .req     (chreq),
      .ptr     (ptr_q),
      .rr_mode (RR != 0),
      .grant_c (pick_c),
      .any_c   (any_c)
   );

   // Address/base of the channel the selector currently favours.
   always_comb begin
      sel_addr = '0;
      sel_base = '0;
      for (int j = 0; j < int'(NCH); j++) begin
         if (PW'(j) == pick_c) begin
            sel_addr = chaddr[j*AW +: AW];
            sel_base = chbase[j*ROMAW +: ROMAW];
         end
      end
   end

   // Channel data sits after the header in ROM; overflow wraps silently.
   assign chan_addr = sel_base + ROMAW'(HDRLEN) + ROMAW'(sel_addr);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      pend_d     = pend_q;
      chack_d    = '0;
      chdata_d   = chdata;
      romaddr_d  = romaddr;
      romreq_d   = romreq;
      header_d   = header;
      hdrvalid_d = hdrvalid;
      start_hdr  = 1'b0;

      case (state_q)
         ST_WAITINIT: begin
            if (init) start_hdr = 1'b1;
         end
         ST_HDR: begin
            if (!romreq) begin
               romreq_d  = 1'b1;
               romaddr_d = ROMAW'(cnt_q);
            end else if (romack) begin
               for (int k = 0; k < int'(HDRLEN); k++) begin
                  if (CW'(k) == cnt_q) header_d[k*BW +: BW] = BW'(romdata);
               end
               romreq_d = 1'b0;
               if (cnt_q == CW'(HDRLEN - 1)) begin
                  hdrvalid_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_IDLE: begin
            if (init) begin
               start_hdr = 1'b1;
            end else if (any_c) begin
               gnt_d     = pick_c;
               romaddr_d = chan_addr;
               romreq_d  = 1'b1;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (init) pend_d = 1'b1;
            if (romack) begin
               chdata_d = romdata;
               romreq_d = 1'b0;
               for (int j = 0; j < int'(NCH); j++) chack_d[j] = (PW'(j) == gnt_q);
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (RR != 0) ptr_d = (gnt_q == PW'(NCH - 1)) ? '0 : gnt_q + PW'(1);
            // An init seen during the transaction (or now) reloads the header.
            if (pend_q || init) begin
               start_hdr = 1'b1;
               pend_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_WAITINIT;
      endcase

      if (start_hdr) begin
         state_d    = ST_HDR;
         cnt_d      = '0;
         hdrvalid_d = 1'b0;
         romreq_d   = 1'b1;
         romaddr_d  = '0;
      end

      busy_d = (state_d == ST_HDR) || (state_d == ST_BUSY) || (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_WAITINIT;
         cnt_q    <= '0;
         ptr_q    <= '0;
         gnt_q    <= '0;
         pend_q   <= 1'b0;
         chack    <= '0;
         chdata   <= '0;
         romaddr  <= '0;
         romreq   <= 1'b0;
         header   <= '0;
         hdrvalid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         pend_q   <= pend_d;
         chack    <= chack_d;
         chdata   <= chdata_d;
         romaddr  <= romaddr_d;
         romreq   <= romreq_d;
         header   <= header_d;
         hdrvalid <= hdrvalid_d;
         busy     <= busy_d;
      end
   end

endmodule
